// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: requester identity and the
// per-access tag that travels alongside each in-flight request.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   is_read;
    logic   killed;
  } tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the port arbiter.
// slave: the arbiter's view; master: requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_flush;
  logic            if_grant;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_grant;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_grant, if_rvalid, if_rdata, d_grant, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_grant, if_rvalid, if_rdata, d_grant, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_tag_pipe.sv
// Two-stage tag shift register matching the 2-cycle memory latency, with
// fetch-flush kill applied to both stages and to the entry being loaded.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  tag_t tag_i,
  output logic if_rvalid_o,
  output logic d_rvalid_o
);

  tag_t tag_p0_q, tag_p0_d;
  tag_t tag_p1_q, tag_p1_d;

  always_comb begin
    tag_p0_d = tag_i;
    tag_p1_d = tag_p0_q;
    if (flush_i && tag_i.owner == OWN_IF)    tag_p0_d.killed = 1'b1;
    if (flush_i && tag_p0_q.owner == OWN_IF) tag_p1_d.killed = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_p0_q <= '0;
      tag_p1_q <= '0;
    end else begin
      tag_p0_q <= tag_p0_d;
      tag_p1_q <= tag_p1_d;
    end
  end

  // Output stage: a flush in the presenting cycle kills the fetch response too.
  always_comb begin
    if_rvalid_o = ~rst & tag_p1_q.valid & (tag_p1_q.owner == OWN_IF) &
                  ~tag_p1_q.killed & ~flush_i;
    d_rvalid_o  = ~rst & tag_p1_q.valid & (tag_p1_q.owner == OWN_D) & tag_p1_q.is_read;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Optional anti-starvation for fetch is enabled with `define ARB_FAIR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  logic if_grant, d_grant, force_if;
  tag_t new_tag;

`ifdef ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_q, starve_d;

  assign force_if = bus.if_req & bus.d_req & (starve_q == CW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_grant) starve_d = '0;
    else if (d_grant)            starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic unused_starve;
  assign unused_starve = ^STARVE_MAX;
  assign force_if      = 1'b0;
`endif

  assign d_grant      = ~rst & bus.d_req & ~force_if;
  assign if_grant     = ~rst & bus.if_req & ~d_grant;
  assign bus.d_grant  = d_grant;
  assign bus.if_grant = if_grant;

  always_comb begin
    bus.mem_en    = if_grant | d_grant;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (d_grant) begin
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (if_grant) begin
      bus.mem_be    = '1;
      bus.mem_addr  = bus.if_addr;
    end
  end

  always_comb begin
    new_tag.valid   = if_grant | d_grant;
    new_tag.owner   = d_grant ? OWN_D : OWN_IF;
    new_tag.is_read = d_grant ? ~bus.d_we : 1'b1;
    new_tag.killed  = 1'b0;
  end

  mem_arb_tag_pipe u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.if_flush),
    .tag_i       (new_tag),
    .if_rvalid_o (bus.if_rvalid),
    .d_rvalid_o  (bus.d_rvalid)
  );

  assign bus.if_rdata = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single pipelined 2-cycle memory port between the instruction-fetch front end and the load/store (data) stage. Grants one requester per cycle and tracks each in-flight request through a 2-deep tag pipeline. Routes returning read data to its owner, and discards fetch responses cancelled by a front-end flush. Sits between the fetch stages / memory stage and the unified memory.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive contended data grants before fetch is forced through (used only with ARB_FAIR_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  AW  fetch address
- if_flush  in  1  cancel all outstanding fetch responses
- if_grant  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request
- d_we  in  1  data write (1) / read (0)
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_grant  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  DW  data read data
- mem_en  out  1  memory request strobe
- mem_we  out  1  memory write
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid 2 cycles after the mem_en cycle

## Operation
- Grant is combinational from the current-cycle requests.
- Arbitration: data wins when both request (strict priority). At most one grant per cycle.
- Winner's fields drive mem_*; fetch drives mem_we=0 and mem_be=all ones.
- mem_en = if_grant | d_grant.
- When no request is granted, mem_addr/mem_wdata are don't-care and mem_we=0.
- A requester that is not granted holds its request. The upstream stage uses ~grant as its stall.
- Tag pipeline: two stages, each entry {valid, owner (IF/D), is_read, killed}.
  - Stage 0 is loaded at the grant cycle.
  - Stage 1 is produced at the output.
- if_rvalid = stage1.valid & owner==IF & ~killed.
- d_rvalid = stage1.valid & owner==D & is_read.
- Writes never produce rvalid.
- if_rdata = d_rdata = mem_rdata (pass-through). The rvalid qualifiers are the only routing.
- if_flush in cycle F sets killed on every IF entry in both tag stages. It also sets killed on an IF grant issued in cycle F.
  - The memory access still occurs.
  - Data entries are unaffected.
  - Fetches granted at F+1 onward are live.
- Reset clears all tag valid bits and the starvation counter.
  - All outputs are 0 during and after reset, until requests arrive.
  - A reset mid-operation drops in-flight responses: no rvalid for grants issued before or during reset.
  - Requests are ignored while rst=1: no grant, mem_en=0.

## Timing
- Request accepted in cycle N: grant and mem_* are asserted in N, and rvalid is asserted in N+2.
- Throughput: one access per cycle, back-to-back, with no bubbles between owners.
- Flush and response in the same cycle: a killed response that would present at F is suppressed, because the kill applies combinationally to stage1.

## Configuration
- ARB_FAIR_EN defined: anti-starvation is enabled.
  - A counter (width clog2(STARVE_MAX+1)) increments on each cycle where if_req and d_req are both high and data is granted.
  - When the counter equals STARVE_MAX, the next contended cycle grants fetch instead, and the counter clears.
  - The counter also clears on any fetch grant or any cycle with if_req=0.
- ARB_FAIR_EN undefined: strict data priority. No counter exists, and STARVE_MAX is unused.

## Structure
- Package mem_arb_pkg holds:
  - owner_t enum {OWN_IF, OWN_D}
  - tag_t struct {valid, owner, is_read, killed}
- Sub-module mem_arb_tag_pipe holds the 2-stage tag shift register with flush-kill and reset. The top level contains the arbitration, muxing and optional fairness counter.

## Test plan
- Fetch only: if_req continuous with addresses 0x0, 0x4, 0x8. Required: if_grant every cycle, and if_rvalid from cycle 2 with data for 0x0, 0x4, 0x8 in order.
- Contention: both requesting in cycle 5 with d_we=0, d_addr=0x100. Required: d_grant=1, if_grant=0, mem_addr=0x100, d_rvalid at cycle 7, and no if_rvalid at cycle 7.
- Write: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF. Required: mem_we=1, mem_be=0011, and no d_rvalid two cycles later.
- Flush: fetches granted at cycles 10, 11, 12, with if_flush at cycle 12 and a fetch at 13. Required: no if_rvalid at cycles 12, 13 or 14, and if_rvalid at cycle 15.
- Reset mid-flight: fetch granted at cycle 3, rst=1 at cycle 4. Required: no if_rvalid at cycle 5, all outputs 0, and no grants while rst=1.
- ARB_FAIR_EN with STARVE_MAX=4: both requesting continuously. Required: grant pattern D, D, D, D, IF repeating. Without the macro, D is granted every cycle.
